// File: rtl/avalon_st_skid_bridge.sv
// rtl/avalon_st_skid_bridge.sv - registered Avalon-ST bridge with skid buffer, framing check and packet counter
module avalon_st_skid_bridge #(
    parameter int DATA_WIDTH  = 32,
    parameter int EMPTY_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_startofpacket,
    input  logic                   in_endofpacket,
    input  logic [EMPTY_WIDTH-1:0] in_empty,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_startofpacket,
    output logic                   out_endofpacket,
    output logic [EMPTY_WIDTH-1:0] out_empty,
    input  logic                   clr_stat,
    output logic [15:0]            pkt_count,
    output logic                   err_framing
);

    // Beat layout: {data, sop, eop, empty}
    localparam int BW = DATA_WIDTH + EMPTY_WIDTH + 2;

    logic [BW-1:0] in_beat;
    logic [BW-1:0] out_beat, out_beat_n;
    logic [BW-1:0] skid_beat, skid_beat_n;
    logic          out_valid_r, out_valid_n;
    logic          skid_valid, skid_valid_n;
    logic          in_ready_r;
    logic          in_fire, out_fire, out_free;
    logic          in_packet;
    logic          framing_bad;

    // Empty is only meaningful on the end-of-packet beat, so it is cleaned on entry
    assign in_beat = {in_data, in_startofpacket, in_endofpacket,
                      in_endofpacket ? in_empty : {EMPTY_WIDTH{1'b0}}};

    assign in_fire  = in_valid && in_ready_r;
    assign out_fire = out_valid_r && out_ready;
    assign out_free = !out_valid_r || out_ready;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign {out_data, out_startofpacket, out_endofpacket, out_empty} = out_beat;

    // Next-state of the two storage stages; SKID always refills OUT before a newer beat
    always_comb begin
        out_valid_n  = out_valid_r;
        out_beat_n   = out_beat;
        skid_valid_n = skid_valid;
        skid_beat_n  = skid_beat;
        if (out_free) begin
            if (skid_valid) begin
                out_beat_n   = skid_beat;
                out_valid_n  = 1'b1;
                skid_valid_n = in_fire;
                if (in_fire) begin
                    skid_beat_n = in_beat;
                end
            end else if (in_fire) begin
                out_beat_n  = in_beat;
                out_valid_n = 1'b1;
            end else begin
                out_valid_n = 1'b0;
            end
        end else if (in_fire) begin
            skid_beat_n  = in_beat;
            skid_valid_n = 1'b1;
        end
    end

    // Register the data path; in_ready is the registered complement of next SKID occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            out_beat    <= '0;
            skid_valid  <= 1'b0;
            skid_beat   <= '0;
            in_ready_r  <= 1'b0;
        end else begin
            out_valid_r <= out_valid_n;
            out_beat    <= out_beat_n;
            skid_valid  <= skid_valid_n;
            skid_beat   <= skid_beat_n;
            in_ready_r  <= !skid_valid_n;
        end
    end

    // A sop inside a packet, or a continuation beat outside one, is a framing error
    assign framing_bad = in_fire && (in_startofpacket ? in_packet : !in_packet);

    // Track packet state on accepted input beats; eop wins so sop+eop leaves it closed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_packet <= 1'b0;
        end else if (in_fire) begin
            if (in_endofpacket) begin
                in_packet <= 1'b0;
            end else if (in_startofpacket) begin
                in_packet <= 1'b1;
            end
        end
    end

    // Statistics: clear has priority over a same-cycle increment or error
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_count   <= 16'd0;
            err_framing <= 1'b0;
        end else if (clr_stat) begin
            pkt_count   <= 16'd0;
            err_framing <= 1'b0;
        end else begin
            if (out_fire && out_endofpacket) begin
                pkt_count <= pkt_count + 16'd1;
            end
            if (framing_bad) begin
                err_framing <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_avalon_st_skid_bridge.sv
// tb/tb_avalon_st_skid_bridge.sv - directed self-checking bench for avalon_st_skid_bridge
module tb_avalon_st_skid_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_startofpacket;
    logic        in_endofpacket;
    logic [1:0]  in_empty;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_startofpacket;
    logic        out_endofpacket;
    logic [1:0]  out_empty;
    logic        clr_stat;
    logic [15:0] pkt_count;
    logic        err_framing;

    int vectors     = 0;
    int miscompares = 0;
    int skid_used   = 0;
    int out_beats   = 0;
    logic [35:0] exp_q[$];

    always #5 clk = ~clk;

    avalon_st_skid_bridge #(.DATA_WIDTH(32), .EMPTY_WIDTH(2)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .in_startofpacket  (in_startofpacket),
        .in_endofpacket    (in_endofpacket),
        .in_empty          (in_empty),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .out_empty         (out_empty),
        .clr_stat          (clr_stat),
        .pkt_count         (pkt_count),
        .err_framing       (err_framing)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic sop,
                         input logic eop, input logic [1:0] e);
        in_valid         = v;
        in_data          = d;
        in_startofpacket = sop;
        in_endofpacket   = eop;
        in_empty         = e;
    endtask

    // One clock: score output transfers against the expected queue, then check stall/skid behaviour
    task automatic step(output logic accepted);
        logic        inf, outf, hold, skid_fill, rel;
        logic [36:0] held;
        logic [35:0] exp_beat;
        inf       = in_valid && in_ready;
        outf      = out_valid && out_ready;
        hold      = out_valid && !out_ready;
        held      = {1'b1, out_data, out_startofpacket, out_endofpacket, out_empty};
        skid_fill = inf && out_valid && !out_ready;
        rel       = (exp_q.size() == 2) && out_ready;
        if (outf) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_beat", {out_data, out_startofpacket, out_endofpacket, out_empty}, 64'hDEAD);
            end else begin
                exp_beat = exp_q.pop_front();
                check("out_beat", {out_data, out_startofpacket, out_endofpacket, out_empty}, exp_beat);
            end
            out_beats++;
        end
        if (inf) begin
            exp_q.push_back({in_data, in_startofpacket, in_endofpacket,
                             in_endofpacket ? in_empty : 2'd0});
        end
        @(posedge clk);
        #1;
        accepted = inf;
        if (hold) begin
            check("stall_hold", {out_valid, out_data, out_startofpacket, out_endofpacket, out_empty}, held);
        end
        if (skid_fill) begin
            skid_used++;
            check("in_ready_drop", in_ready, 0);
        end
        if (rel) begin
            check("in_ready_release", in_ready, 1);
        end
    endtask

    initial begin
        logic        acc;
        logic [31:0] pat;
        int          idx;

        reset_n   = 1'b0;
        out_ready = 1'b0;
        clr_stat  = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 2'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_err", err_framing, 0);
        check("rst_out_data", out_data, 0);

        // Reset release: in_ready stays low until the first edge
        reset_n = 1'b1;
        #1;
        check("rel_in_ready_pre", in_ready, 0);
        step(acc);
        check("rel_in_ready_post", in_ready, 1);
        check("rel_out_valid", out_valid, 0);

        // 8-beat packet, no backpressure: one-cycle latency, no bubbles
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'(i), i == 1, i == 8, (i == 8) ? 2'd2 : 2'd0);
            step(acc);
            check("stream_valid", out_valid, 1);
            check("stream_data", out_data, i);
        end
        drive(1'b0, 32'd0, 1'b0, 1'b0, 2'd0);
        step(acc);
        check("stream_idle", out_valid, 0);
        check("stream_pkt_count", pkt_count, 1);
        check("stream_q_empty", exp_q.size(), 0);

        // Same packet with toggling out_ready
        pat       = 32'b1101_0011_0100_1001_1000_1010_0110_0101;
        idx       = 1;
        out_beats = 0;
        for (int k = 0; k < 60; k++) begin
            out_ready = (k < 32) ? pat[k] : 1'b1;
            if (idx <= 8) begin
                drive(1'b1, 32'(idx), idx == 1, idx == 8, (idx == 8) ? 2'd2 : 2'd0);
            end else begin
                drive(1'b0, 32'd0, 1'b0, 1'b0, 2'd0);
            end
            step(acc);
            if (acc) idx++;
        end
        check("bp_all_accepted", idx, 9);
        check("bp_all_delivered", out_beats, 8);
        check("bp_q_empty", exp_q.size(), 0);
        check("bp_skid_used", skid_used > 0, 1);
        check("bp_pkt_count", pkt_count, 2);

        // Clear, then three single-beat packets and a sop beat carrying a stray empty
        out_ready = 1'b1;
        clr_stat  = 1'b1;
        step(acc);
        clr_stat = 1'b0;
        check("clr_pkt_count", pkt_count, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hA0 + 32'(i), 1'b1, 1'b1, 2'd1);
            step(acc);
        end
        drive(1'b1, 32'hB0, 1'b1, 1'b0, 2'd3);
        step(acc);
        check("masked_data", out_data, 32'hB0);
        check("masked_empty", out_empty, 0);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 2'd0);
        step(acc);
        check("single_pkt_count", pkt_count, 3);
        check("single_err", err_framing, 0);
        drive(1'b1, 32'hB1, 1'b0, 1'b1, 2'd1);
        step(acc);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 2'd0);
        step(acc);
        check("close_pkt_count", pkt_count, 4);
        check("close_err", err_framing, 0);

        // Missing eop: second sop flags a framing error, both beats still forwarded
        drive(1'b1, 32'hC0, 1'b1, 1'b0, 2'd0);
        step(acc);
        check("sop1_err", err_framing, 0);
        drive(1'b1, 32'hC1, 1'b1, 1'b0, 2'd0);
        step(acc);
        check("sop2_err", err_framing, 1);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 2'd0);
        step(acc);
        step(acc);
        check("sop_q_empty", exp_q.size(), 0);
        out_ready = 1'b0;
        drive(1'b1, 32'hC2, 1'b0, 1'b1, 2'd3);
        step(acc);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 2'd0);
        check("pre_clr_pkt_count", pkt_count, 4);
        check("pre_clr_err", err_framing, 1);
        out_ready = 1'b1;
        clr_stat  = 1'b1;
        step(acc);
        clr_stat = 1'b0;
        check("clr_wins_pkt_count", pkt_count, 0);
        check("clr_wins_err", err_framing, 0);

        // Counter wrap: 65535 single-beat packets then one more
        for (int i = 0; i < 65535; i++) begin
            drive(1'b1, 32'(i), 1'b1, 1'b1, 2'd0);
            step(acc);
        end
        drive(1'b0, 32'd0, 1'b0, 1'b0, 2'd0);
        step(acc);
        check("wrap_ffff", pkt_count, 16'hFFFF);
        drive(1'b1, 32'h1234, 1'b1, 1'b1, 2'd0);
        step(acc);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 2'd0);
        step(acc);
        check("wrap_zero", pkt_count, 0);

        // Reset with both stages full discards the buffered beats
        out_ready = 1'b0;
        drive(1'b1, 32'hD0, 1'b1, 1'b0, 2'd0);
        step(acc);
        drive(1'b1, 32'hD1, 1'b0, 1'b0, 2'd0);
        step(acc);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 2'd0);
        check("full_in_ready", in_ready, 0);
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_data", out_data, 0);
        exp_q.delete();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(acc);
        check("midrst_no_out", out_valid, 0);
        check("midrst_ready_back", in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
